// File: rtl/npu_adder_pkg.sv
// Shared constants and elaboration-time helpers for the adder tree.
// clog2/SUM_W size the operand sum; row_out/lvl_n/lvl_off/num_lvls describe
// the shape of the carry-save reduction tree (vectors per level and the
// offset of each level inside the flat tree bus).
package npu_adder_pkg;

  localparam int PIPE_LAT = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int SUM_W(input int n, input int w);
    return w + clog2(n);
  endfunction

  // Vectors left after one compressor row: each 5-group yields 3, a
  // remainder of 3 or 4 spends a 3:2 (3 -> 2), anything else passes through.
  function automatic int row_out(input int n);
    int r;
    r = n % 5;
    return 3 * (n / 5) + ((r >= 3) ? r - 1 : r);
  endfunction

  function automatic int num_lvls(input int n);
    int x, c;
    x = n;
    c = 0;
    for (int i = 0; i < 64; i++)
      if (x > 2) begin
        x = row_out(x);
        c++;
      end
    return c;
  endfunction

  function automatic int lvl_n(input int n, input int l);
    int x;
    x = n;
    for (int i = 0; i < 64; i++)
      if (i < l && x > 2) x = row_out(x);
    return x;
  endfunction

  function automatic int lvl_off(input int n, input int l);
    int o;
    o = 0;
    for (int i = 0; i < 64; i++)
      if (i < l) o += lvl_n(n, i);
    return o;
  endfunction

endpackage

// File: rtl/compress_row.sv
// One row of the carry-save reduction tree.
// din  : N vectors of W bits
// dout : M = row_out(N) vectors of W bits with the same sum modulo 2^W
// Groups of five go through 5:3 counters, a remainder of 3/4 uses one 3:2,
// leftover vectors pass through untouched.
module compress_row
  import npu_adder_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8,
  parameter int M = row_out(N)
) (
  input  logic [N-1:0][W-1:0] din,
  output logic [M-1:0][W-1:0] dout
);

  localparam int G5 = N / 5;
  localparam int R  = N % 5;
  localparam int G3 = (R >= 3) ? 1 : 0;
  localparam int NP = R - 3 * G3;

  for (genvar g = 0; g < G5; g++) begin : g_c53
    logic [W-1:0] s, c, d;
    // per-bit population count of five bits, weights 1/2/4
    always_comb begin
      s = '0;
      c = '0;
      d = '0;
      for (int i = 0; i < W; i++)
        {d[i], c[i], s[i]} = 3'(din[5*g][i]) + 3'(din[5*g+1][i]) +
                             3'(din[5*g+2][i]) + 3'(din[5*g+3][i]) +
                             3'(din[5*g+4][i]);
    end
    assign dout[3*g]   = s;
    assign dout[3*g+1] = c << 1;
    assign dout[3*g+2] = d << 2;
  end

  if (G3 != 0) begin : g_c32
    logic [W-1:0] a, b, e;
    assign a = din[5*G5];
    assign b = din[5*G5+1];
    assign e = din[5*G5+2];
    assign dout[3*G5]   = a ^ b ^ e;
    assign dout[3*G5+1] = ((a & b) | (a & e) | (b & e)) << 1;
  end

  for (genvar p = 0; p < NP; p++) begin : g_pass
    assign dout[3*G5+2*G3+p] = din[5*G5+3*G3+p];
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Three-stage pipelined multi-operand adder.
//   S1: operand capture, S2: carry-save tree down to two ACC_W vectors,
//   S3: carry-propagate add (plus group accumulation when enabled).
// Ports: clk, reset (async, active high); in_valid/in_ready/in_data/in_last
// operand beat handshake; out_valid/out_ready/out_sum result handshake.
// Stall is global: any stage holds while out_valid && !out_ready.
// Macro ADDER_TREE_ACC_EN: accumulate beats and emit one result per
// in_last group; otherwise every accepted beat yields one result.
module adder_tree_pipe
  import npu_adder_pkg::*;
#(
  parameter int N_IN   = 9,
  parameter int W      = 8,
  parameter int SIGNED = 1,
  parameter int ACC_W  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum
);

  localparam int NL  = num_lvls(N_IN);
  localparam int TOT = lvl_off(N_IN, NL) + 2;

  logic                       stall;
  logic [1:0]                 vld_pipe;   // [0] = S1, [1] = S2
  logic [N_IN*W-1:0]          s1_data;
  logic [TOT-1:0][ACC_W-1:0]  tree;       // all tree levels, level 0 first
  logic [ACC_W-1:0]           s2_a, s2_b, beat_sum;

`ifdef ADDER_TREE_ACC_EN
  logic                       s1_last, s2_last;
  logic [ACC_W-1:0]           acc;
`else
  logic                       unused_last;
  assign unused_last = in_last;
`endif

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // level 0: operands extended to accumulator width
  for (genvar k = 0; k < N_IN; k++) begin : g_ext
    logic [W-1:0] op;
    assign op = s1_data[k*W +: W];
    if (SIGNED != 0) begin : g_sx
      assign tree[k] = {{(ACC_W-W){op[W-1]}}, op};
    end else begin : g_zx
      assign tree[k] = {{(ACC_W-W){1'b0}}, op};
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_lvl
    compress_row #(
      .N (lvl_n(N_IN, l)),
      .W (ACC_W)
    ) u_row (
      .din  (tree[lvl_off(N_IN, l)   +: lvl_n(N_IN, l)]),
      .dout (tree[lvl_off(N_IN, l+1) +: lvl_n(N_IN, l+1)])
    );
  end

  assign beat_sum = s2_a + s2_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      s1_data   <= '0;
      s2_a      <= '0;
      s2_b      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef ADDER_TREE_ACC_EN
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      acc       <= '0;
`endif
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[0], in_valid};
      s1_data  <= in_data;
      s2_a     <= tree[TOT-2];
      s2_b     <= tree[TOT-1];
`ifdef ADDER_TREE_ACC_EN
      s1_last  <= in_last;
      s2_last  <= s1_last;
      // bubbles leave acc untouched; a last beat emits and restarts the group
      if (vld_pipe[1]) begin
        if (s2_last) begin
          out_sum   <= acc + beat_sum;
          acc       <= '0;
          out_valid <= 1'b1;
        end else begin
          acc       <= acc + beat_sum;
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
`else
      out_valid <= vld_pipe[1];
      if (vld_pipe[1]) out_sum <= beat_sum;
`endif
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
module tb_adder_tree_pipe;

  localparam int N_IN = 9;
  localparam int W    = 8;
  localparam int AW   = 24;
  localparam int AW2  = 12;
  localparam int DW   = N_IN * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, in_ready2, out_valid2;
  logic [AW-1:0] out_sum;
  logic [AW2-1:0] out_sum2;

  always #5 clk = ~clk;

  adder_tree_pipe #(.N_IN(N_IN), .W(W), .SIGNED(1), .ACC_W(AW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum));

  adder_tree_pipe #(.N_IN(N_IN), .W(W), .SIGNED(0), .ACC_W(AW2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_sum(out_sum2));

  int checks = 0;
  int errors = 0;
  longint q_s[$], q_u[$];
  longint acc_s = 0, acc_u = 0;
  bit prev_stall = 0, acc_flag = 0;
  logic [63:0] prev_sum, prev_sum2, last_out, last_out2;

  localparam longint MASK1 = (longint'(1) << AW) - 1;
  localparam longint MASK2 = (longint'(1) << AW2) - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // plain integer sum of the operands as the spec defines them
  function automatic longint ref_sum(input logic [DW-1:0] d, input bit sgn);
    longint s;
    logic [W-1:0] op;
    s = 0;
    for (int k = 0; k < N_IN; k++) begin
      op = d[k*W +: W];
      if (sgn) s += longint'($signed(op));
      else     s += longint'(op);
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [W-1:0] v);
    return {N_IN{v}};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*W +: W] = W'($urandom);
    return d;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input bit l);
`ifdef ADDER_TREE_ACC_EN
    acc_s += ref_sum(d, 1);
    acc_u += ref_sum(d, 0);
    if (l) begin
      q_s.push_back(acc_s & MASK1);
      q_u.push_back(acc_u & MASK2);
      acc_s = 0;
      acc_u = 0;
    end
`else
    q_s.push_back(ref_sum(d, 1) & MASK1);
    q_u.push_back(ref_sum(d, 0) & MASK2);
`endif
  endtask

  // one clock: drive at negedge, check pre-edge outputs, update the model
  task automatic cyc_step(input bit v, input logic [DW-1:0] d, input bit l, input bit ordy);
    bit stall;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    stall = out_valid && !out_ready;
    chk("in_ready", in_ready, !stall);
    chk("in_ready2", in_ready2, !stall);
    chk("out_valid2", out_valid2, out_valid);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", out_sum, prev_sum);
      chk("hold_sum2", out_sum2, prev_sum2);
    end
    acc_flag = v && in_ready;
    if (acc_flag) model_accept(d, l);
    if (out_valid && out_ready) begin
      if (q_s.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        chk("out_sum", out_sum, q_s.pop_front());
        chk("out_sum2", out_sum2, q_u.pop_front());
        last_out = out_sum;
        last_out2 = out_sum2;
      end
    end
    prev_stall = stall;
    prev_sum = out_sum;
    prev_sum2 = out_sum2;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l);
    for (int t = 0; t < 20; t++) begin
      cyc_step(1'b1, d, l, 1'b1);
      if (acc_flag) break;
    end
    if (!acc_flag) chk("send_timeout", acc_flag, 1'b1);
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && q_s.size() > 0; t++) cyc_step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_left", q_s.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_sum2", out_sum2, 0);
    q_s.delete(); q_u.delete();
    acc_s = 0; acc_u = 0; prev_stall = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] beats [10];
    int i;

    do_reset();

    // 0x7F everywhere: 1143, result visible exactly three cycles later
    cyc_step(1'b1, fill(8'h7F), 1'b1, 1'b1);
    cyc_step(1'b0, '0, 1'b0, 1'b1);
    chk("lat_c1", out_valid, 1'b0);
    cyc_step(1'b0, '0, 1'b0, 1'b1);
    chk("lat_c2", out_valid, 1'b0);
    cyc_step(1'b0, '0, 1'b0, 1'b1);
    chk("lat_c3", out_valid, 1'b1);
    chk("sum_7f", last_out, 1143);
    chk("sum2_7f", last_out2, 1143);

    // most negative operand
    send(fill(8'h80), 1'b1);
    drain();
    chk("sum_80", last_out, 24'hFFFB80);
    chk("sum2_80", last_out2, 1152);

    // ten back-to-back beats, downstream stalls cycles 4..7
    for (int k = 0; k < 10; k++) beats[k] = rnd_data();
    i = 0;
    for (int t = 0; t < 40 && i < 10; t++) begin
      cyc_step(1'b1, beats[i], 1'b1, !(t >= 4 && t <= 7));
      if (acc_flag) i++;
    end
    chk("b2b_sent", i, 10);
    drain();

    // randomized traffic with random backpressure and group boundaries
    for (int t = 0; t < 300; t++)
      cyc_step(1'($urandom_range(0, 3) != 0), rnd_data(),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
    send(rnd_data(), 1'b1);
    drain();

    // reset in the middle of a group discards the partial work
    send(fill(8'h05), 1'b0);
    send(fill(8'h07), 1'b0);
    do_reset();
    send(fill(8'h02), 1'b1);
    drain();
    chk("after_rst", last_out, 18);
    chk("after_rst2", last_out2, 18);

    // four-beat group of ones
    for (int k = 0; k < 4; k++) send(fill(8'h01), k == 3);
    drain();
`ifdef ADDER_TREE_ACC_EN
    chk("grp_ones", last_out, 36);
`else
    chk("grp_ones", last_out, 9);
`endif

    // twenty beats of 0xFF
    for (int k = 0; k < 20; k++) send(fill(8'hFF), k == 19);
    drain();
`ifdef ADDER_TREE_ACC_EN
    chk("grp_ff_u", last_out2, 844);
    chk("grp_ff_s", last_out, 24'hFFFF4C);
`else
    chk("grp_ff_u", last_out2, 2295);
    chk("grp_ff_s", last_out, 24'hFFFFF7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
